// File: rtl/scs8hd_or_tree_pipe.sv
// ---------------------------------------------------------------------------
// scs8hd_or_tree_pipe
//   Pipelined multi-channel OR-reduction with a valid/ready handshake and an
//   optional sticky accumulator. Each of CH channels reduces WIDTH bits through
//   a registered radix-3 OR tree. Partial groups at each level are zero-padded.
//   Latency is L = max(1, ceil(log3(WIDTH))) cycles and throughput is one beat
//   per cycle.
//
// Ports
//   CLK        in   1         clock, rising edge
//   RESETB     in   1         asynchronous active-low reset
//   A          in   CH*WIDTH  channel c occupies A[c*WIDTH +: WIDTH]
//   VALID_IN   in   1         A is valid this cycle
//   READY_OUT  out  1         block accepts A this cycle (combinational)
//   X          out  CH        per-channel OR result (combinational on STICKY)
//   VALID_OUT  out  1         X is valid this cycle
//   READY_IN   in   1         downstream accepts X this cycle
//   STICKY     in   1         1 = OR the accumulator into X
//   CLR        in   1         synchronous clear of the accumulator
// ---------------------------------------------------------------------------
module scs8hd_or_tree_pipe #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned CH    = 2
) (
  input  logic                  CLK,
  input  logic                  RESETB,
  input  logic [CH*WIDTH-1:0]   A,
  input  logic                  VALID_IN,
  output logic                  READY_OUT,
  output logic [CH-1:0]         X,
  output logic                  VALID_OUT,
  input  logic                  READY_IN,
  input  logic                  STICKY,
  input  logic                  CLR
);

  // Per-channel bit count after k radix-3 reductions.
  function automatic int unsigned f_lvl_w(input int unsigned w, input int unsigned k);
    int unsigned r;
    r = w;
    for (int unsigned i = 0; i < k; i++) begin
      r = (r + 2) / 3;
    end
    return r;
  endfunction

  // Number of registered levels; at least one even when WIDTH=1.
  function automatic int unsigned f_levels(input int unsigned w);
    int unsigned r;
    int unsigned n;
    r = w;
    n = 0;
    while (r > 1) begin
      r = (r + 2) / 3;
      n++;
    end
    return (n == 0) ? 1 : n;
  endfunction

  localparam int unsigned L = f_levels(WIDTH);

  logic          w_en;
  logic [CH-1:0] w_r;
  logic [CH-1:0] r_acc;

  // Global advance: bubbles are not squeezed out, the whole tree moves together.
  assign w_en      = !VALID_OUT || READY_IN;
  assign READY_OUT = w_en;

  for (genvar k = 1; k <= L; k++) begin : g_lvl
    localparam int unsigned WP = f_lvl_w(WIDTH, k - 1);
    localparam int unsigned WC = f_lvl_w(WIDTH, k);

    logic [CH*WP-1:0]   w_prev;
    logic               w_prev_vld;
    logic [CH*3*WC-1:0] w_pad;
    logic [CH*WC-1:0]   w_next;
    logic [CH*WC-1:0]   r_data;
    logic               r_vld;

    if (k == 1) begin : g_src
      assign w_prev     = A;
      assign w_prev_vld = VALID_IN;
    end else begin : g_src
      assign w_prev     = g_lvl[k-1].r_data;
      assign w_prev_vld = g_lvl[k-1].r_vld;
    end

    // Zero-extend each channel to a whole number of 3-bit groups.
    always_comb begin
      w_pad = '0;
      for (int unsigned c = 0; c < CH; c++) begin
        w_pad[c*3*WC +: 3*WC] = (3*WC)'(w_prev[c*WP +: WP]);
      end
    end

    // One OR3 per group.
    always_comb begin
      w_next = '0;
      for (int unsigned c = 0; c < CH; c++) begin
        for (int unsigned j = 0; j < WC; j++) begin
          w_next[c*WC + j] = |w_pad[c*3*WC + 3*j +: 3];
        end
      end
    end

    // Level register: loads on advance, holds otherwise.
    always_ff @(posedge CLK or negedge RESETB) begin
      if (!RESETB) begin
        r_data <= '0;
        r_vld  <= 1'b0;
      end else if (w_en) begin
        r_data <= w_next;
        r_vld  <= w_prev_vld;
      end
    end
  end

  assign w_r       = g_lvl[L].r_data;
  assign VALID_OUT = g_lvl[L].r_vld;

  // Sticky accumulator; a coincident CLR still lets the current beat see the old value.
  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      r_acc <= '0;
    end else if (CLR) begin
      r_acc <= '0;
    end else if (VALID_OUT && READY_IN) begin
      r_acc <= r_acc | X;
    end
  end

  assign X = w_r | (STICKY ? r_acc : '0);

endmodule

// File: tb/tb_scs8hd_or_tree_pipe.sv
module tb_scs8hd_or_tree_pipe;

  localparam int unsigned SW_W [4] = '{1, 3, 4, 27};
  localparam int unsigned SW_L [4] = '{1, 1, 2, 3};

  logic        CLK      = 1'b0;
  logic        RESETB   = 1'b1;
  logic [17:0] A        = '0;
  logic        VALID_IN = 1'b0;
  logic        READY_IN = 1'b1;
  logic        STICKY   = 1'b0;
  logic        CLR      = 1'b0;
  logic        READY_OUT;
  logic        VALID_OUT;
  logic [1:0]  X;

  logic [1:0]  a_w1  = '0;
  logic [5:0]  a_w3  = '0;
  logic [7:0]  a_w4  = '0;
  logic [53:0] a_w27 = '0;
  logic        sw_vld = 1'b0;
  logic [1:0]  x_sw [4];
  logic        v_sw [4];
  logic        r_sw [4];

  int          n_vec = 0;
  int          n_err = 0;
  logic [1:0]  sb_q [$];
  logic [1:0]  m_acc = '0;

  always #5 CLK = ~CLK;

  scs8hd_or_tree_pipe #(.WIDTH(9), .CH(2)) u_dut (
    .CLK(CLK), .RESETB(RESETB), .A(A), .VALID_IN(VALID_IN), .READY_OUT(READY_OUT),
    .X(X), .VALID_OUT(VALID_OUT), .READY_IN(READY_IN), .STICKY(STICKY), .CLR(CLR));

  scs8hd_or_tree_pipe #(.WIDTH(1), .CH(2)) u_w1 (
    .CLK(CLK), .RESETB(RESETB), .A(a_w1), .VALID_IN(sw_vld), .READY_OUT(r_sw[0]),
    .X(x_sw[0]), .VALID_OUT(v_sw[0]), .READY_IN(1'b1), .STICKY(1'b0), .CLR(1'b0));

  scs8hd_or_tree_pipe #(.WIDTH(3), .CH(2)) u_w3 (
    .CLK(CLK), .RESETB(RESETB), .A(a_w3), .VALID_IN(sw_vld), .READY_OUT(r_sw[1]),
    .X(x_sw[1]), .VALID_OUT(v_sw[1]), .READY_IN(1'b1), .STICKY(1'b0), .CLR(1'b0));

  scs8hd_or_tree_pipe #(.WIDTH(4), .CH(2)) u_w4 (
    .CLK(CLK), .RESETB(RESETB), .A(a_w4), .VALID_IN(sw_vld), .READY_OUT(r_sw[2]),
    .X(x_sw[2]), .VALID_OUT(v_sw[2]), .READY_IN(1'b1), .STICKY(1'b0), .CLR(1'b0));

  scs8hd_or_tree_pipe #(.WIDTH(27), .CH(2)) u_w27 (
    .CLK(CLK), .RESETB(RESETB), .A(a_w27), .VALID_IN(sw_vld), .READY_OUT(r_sw[3]),
    .X(x_sw[3]), .VALID_OUT(v_sw[3]), .READY_IN(1'b1), .STICKY(1'b0), .CLR(1'b0));

  task automatic test_reset();
    #1 RESETB = 1'b0;
    #2;
    n_vec++;
    if (X !== 2'b00 || VALID_OUT !== 1'b0 || READY_OUT !== 1'b1) begin
      n_err++;
      $display("FAIL reset_init X=%b VALID_OUT=%b READY_OUT=%b required 00/0/1", X, VALID_OUT, READY_OUT);
    end
    repeat (2) @(posedge CLK);
    #1 RESETB = 1'b1;
    // Two beats in flight, then reset while the first sits at the output.
    @(posedge CLK); #1 A = 18'h3ffff; VALID_IN = 1'b1;
    @(posedge CLK); #1 A = 18'h00001;
    @(posedge CLK); #1 VALID_IN = 1'b0; A = '0;
    n_vec++;
    if (VALID_OUT !== 1'b1) begin
      n_err++;
      $display("FAIL reset_pre VALID_OUT=%b required 1", VALID_OUT);
    end
    #2 RESETB = 1'b0;
    #1;
    n_vec++;
    if (X !== 2'b00 || VALID_OUT !== 1'b0 || READY_OUT !== 1'b1) begin
      n_err++;
      $display("FAIL reset_mid X=%b VALID_OUT=%b READY_OUT=%b required 00/0/1", X, VALID_OUT, READY_OUT);
    end
    @(posedge CLK); #1 RESETB = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      n_vec++;
      if (VALID_OUT !== 1'b0) begin
        n_err++;
        $display("FAIL reset_stale cyc=%0d VALID_OUT=%b required 0", i, VALID_OUT);
      end
    end
  endtask

  task automatic test_single();
    @(posedge CLK); #1 A = {9'h100, 9'h000}; VALID_IN = 1'b1;
    for (int cyc = 1; cyc <= 3; cyc++) begin
      @(posedge CLK); #1 VALID_IN = 1'b0; A = '0;
      n_vec++;
      if (VALID_OUT !== (cyc == 2) || (cyc == 2 && X !== 2'b10)) begin
        n_err++;
        $display("FAIL single cyc=%0d VALID_OUT=%b X=%b required %b/10", cyc, VALID_OUT, X, (cyc == 2));
      end
    end
  endtask

  task automatic test_stream();
    logic [3:0] pat;
    logic [8:0] c1 [4];
    logic [1:0] xe;
    pat = 4'b1101;                  // bit i = beat i: 1,0,1,1
    for (int i = 0; i < 4; i++) c1[i] = 9'($urandom_range(0, 1) != 0 ? $urandom : 0);
    for (int i = 0; i < 7; i++) begin
      @(posedge CLK); #1;
      if (i < 4) begin
        A = {c1[i], pat[i], 8'h00};
        VALID_IN = 1'b1;
      end else begin
        VALID_IN = 1'b0;
      end
      if (i >= 2 && i <= 5) begin
        xe = {|c1[i-2], pat[i-2]};
        n_vec++;
        if (VALID_OUT !== 1'b1 || X !== xe) begin
          n_err++;
          $display("FAIL stream beat=%0d VALID_OUT=%b X=%b required 1/%b", i - 2, VALID_OUT, X, xe);
        end
      end else if (i == 6) begin
        n_vec++;
        if (VALID_OUT !== 1'b0) begin
          n_err++;
          $display("FAIL stream_end VALID_OUT=%b required 0", VALID_OUT);
        end
      end
    end
  endtask

  task automatic test_stall();
    logic [17:0] beats [6];
    logic [1:0]  xh;
    int          nb;
    nb = 0;
    xh = '0;
    for (int i = 0; i < 6; i++) beats[i] = 18'($urandom) & (i % 2 == 0 ? 18'h3ffff : 18'h20100);
    for (int it = 0; it < 14; it++) begin
      @(posedge CLK); #1;
      READY_IN = !(it >= 3 && it <= 5);
      if (nb < 6) begin
        A = beats[nb];
        VALID_IN = 1'b1;
      end else begin
        VALID_IN = 1'b0;
      end
      @(negedge CLK);
      if (VALID_IN && READY_OUT) nb++;
      if (it >= 3 && it <= 5) begin
        n_vec++;
        if (VALID_OUT !== 1'b1 || READY_OUT !== 1'b0) begin
          n_err++;
          $display("FAIL stall_hs it=%0d VALID_OUT=%b READY_OUT=%b required 1/0", it, VALID_OUT, READY_OUT);
        end
        if (it == 3) xh = X;
        else begin
          n_vec++;
          if (X !== xh) begin
            n_err++;
            $display("FAIL stall_hold it=%0d X=%b required %b", it, X, xh);
          end
        end
      end
    end
    n_vec++;
    if (nb != 6 || sb_q.size() != 0 || VALID_OUT !== 1'b0) begin
      n_err++;
      $display("FAIL stall_drain accepted=%0d pending=%0d VALID_OUT=%b required 6/0/0", nb, sb_q.size(), VALID_OUT);
    end
  endtask

  task automatic test_sticky();
    // {pre-clear pulse, ch0 data, CLR with the output beat, expected X[0]}
    logic        pre [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [8:0]  dat [6] = '{9'h004, 9'h000, 9'h000, 9'h001, 9'h000, 9'h000};
    logic        cw  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic        ex  [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    @(posedge CLK); #1 STICKY = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (pre[i]) begin
        @(posedge CLK); #1 CLR = 1'b1;
        @(posedge CLK); #1 CLR = 1'b0;
      end
      @(posedge CLK); #1 A = {9'h000, dat[i]}; VALID_IN = 1'b1;
      @(posedge CLK); #1 VALID_IN = 1'b0;
      @(posedge CLK); #1 CLR = cw[i];
      @(negedge CLK);
      n_vec++;
      if (VALID_OUT !== 1'b1 || X !== {1'b0, ex[i]}) begin
        n_err++;
        $display("FAIL sticky step=%0d VALID_OUT=%b X=%b required 1/0%b", i, VALID_OUT, X, ex[i]);
      end
      @(posedge CLK); #1 CLR = 1'b0;
    end
    @(posedge CLK); #1 STICKY = 1'b0;
  endtask

  task automatic test_width_sweep();
    logic [1:0] xe [4];
    for (int p = 0; p < 54; p++) begin
      @(posedge CLK); #1;
      a_w1   = 2'(1)  << (p % 2);
      a_w3   = 6'(1)  << (p % 6);
      a_w4   = 8'(1)  << (p % 8);
      a_w27  = 54'(1) << p;
      sw_vld = 1'b1;
      for (int i = 0; i < 4; i++) xe[i] = 2'(1) << ((p % (2 * SW_W[i])) / SW_W[i]);
      for (int cyc = 1; cyc <= 3; cyc++) begin
        @(posedge CLK); #1 sw_vld = 1'b0;
        for (int i = 0; i < 4; i++) begin
          n_vec++;
          if (r_sw[i] !== 1'b1 || v_sw[i] !== (cyc == SW_L[i]) || (v_sw[i] === 1'b1 && x_sw[i] !== xe[i])) begin
            n_err++;
            $display("FAIL sweep_w%0d pos=%0d cyc=%0d VALID_OUT=%b X=%b READY_OUT=%b required %b/%b/1",
                     SW_W[i], p, cyc, v_sw[i], x_sw[i], r_sw[i], (cyc == SW_L[i]), xe[i]);
          end
        end
      end
    end
  endtask

  initial begin
    fork
      // Scoreboard: push raw OR on acceptance, pop and compare on consumption.
      begin : mon
        logic [1:0] xe;
        logic       hs;
        forever begin
          @(negedge CLK);
          if (!RESETB) begin
            sb_q.delete();
            m_acc = '0;
          end else begin
            hs = VALID_OUT && READY_IN;
            xe = X;
            n_vec++;
            if (READY_OUT !== (!VALID_OUT || READY_IN)) begin
              n_err++;
              $display("FAIL ready_out READY_OUT=%b required %b", READY_OUT, (!VALID_OUT || READY_IN));
            end
            if (hs) begin
              n_vec++;
              if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected X=%b required no beat", X);
              end else begin
                xe = sb_q.pop_front() | (STICKY ? m_acc : 2'b00);
                if (X !== xe) begin
                  n_err++;
                  $display("FAIL sb_data X=%b required %b", X, xe);
                end
              end
            end
            m_acc = CLR ? 2'b00 : (hs ? (m_acc | xe) : m_acc);
            if (VALID_IN && READY_OUT) sb_q.push_back({|A[17:9], |A[8:0]});
          end
        end
      end
      begin : run
        test_reset();
        test_single();
        test_stream();
        test_stall();
        test_sticky();
        test_width_sweep();
        repeat (4) @(posedge CLK);
        @(negedge CLK);
        n_vec++;
        if (sb_q.size() != 0) begin
          n_err++;
          $display("FAIL sb_leftover pending=%0d required 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
      end
    join_any
  end

endmodule
